screen_nav_control: RTL and testbench
=====================================

# screen_nav_control

Parametrised screen-navigation controller for the game's UI front end: tracks which of N_SCREENS full-screen layers is active and selects that layer's pixel colour for the display pipeline. It decodes mouse clicks against one per-screen navigation button and one global EXIT button. It sits between the mouse/draw pipeline and the VGA output stage. Clicks are edge-detected and rate-limited so one press causes exactly one transition.

## Interface
Parameters:
- N_SCREENS, 4, number of screens; screen 0 is the menu (2..16)
- SCREEN_W, 2, width of screen index; 2**SCREEN_W >= N_SCREENS
- COORD_W, 12, mouse coordinate width
- RGB_W, 12, pixel colour width
- BTN_X0 / BTN_X1 / BTN_Y0 / BTN_Y1, {N_SCREENS{12'd0}}, flattened per-screen nav-button bounds, inclusive; slice i = [i*COORD_W +: COORD_W]
- BTN_TARGET, {N_SCREENS{2'd0}}, flattened per-screen destination index, slice i = [i*SCREEN_W +: SCREEN_W]
- EXIT_X0 / EXIT_X1 / EXIT_Y0 / EXIT_Y1, 993 / 1013 / 10 / 30, global EXIT button bounds, inclusive
- HOLDOFF, 1023, cycles after a transition during which clicks are ignored (>= 1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- xpos_mouse, ypos_mouse  in  COORD_W  current mouse position
- left_button  in  1  level of the left mouse button
- rgb_screens  in  N_SCREENS*RGB_W  per-screen pixel colour; slice i = [i*RGB_W +: RGB_W]
- xpos_mouse_out, ypos_mouse_out  out  COORD_W  mouse position delayed one cycle
- rgb  out  RGB_W  pixel colour of the active screen
- screen  out  SCREEN_W  active screen index
- screen_changed  out  1  one-cycle pulse, high in the first cycle `screen` holds a new value
- busy  out  1  high while the hold-off counter is non-zero

## Operation
- Edge detect: btn_prev register; click = left_button & ~btn_prev & (holdoff_cnt == 0).
- Hit tests use unsigned compares, bounds inclusive, on the current-cycle xpos_mouse/ypos_mouse.
  - nav_hit: box of slice[screen].
  - exit_hit: EXIT box.
- State is the `screen` register. Next-state on click:
  - exit_hit and screen != 0 -> 0. EXIT has priority over nav_hit when boxes overlap.
  - Else nav_hit and BTN_TARGET[screen] < N_SCREENS and BTN_TARGET[screen] != screen -> BTN_TARGET[screen].
  - Else no change. This covers exit on screen 0, out-of-range target and self-target.
- A transition happens only when `screen` actually changes. On a transition:
  - holdoff_cnt loads HOLDOFF.
  - screen_changed is asserted.
- holdoff_cnt decrements by 1 per cycle to 0 and saturates there. busy = (holdoff_cnt != 0).
- btn_prev updates every cycle, including during hold-off. A press that starts during hold-off and is still held afterwards does not click.
- rgb <= rgb_screens slice[screen], using the registered `screen`.
- Mouse outputs are pure one-cycle delay registers.

## Timing
- Reset (rst low, asynchronous), all registers cleared immediately:
  - screen = 0, rgb = 0, xpos/ypos_mouse_out = 0, screen_changed = 0, holdoff_cnt = 0, busy = 0.
  - btn_prev = 1, so a button held through reset release does not click.
- Reset deassertion is used synchronously to clk. Reset mid-hold-off or mid-transition abandons all state; no pulse is emitted.
- Click latency:
  - Rising-edge sample at cycle T.
  - `screen` and screen_changed update at edge T+1.
  - rgb shows the new screen at edge T+2.
- screen_changed is exactly 1 cycle wide per transition.
- After a transition at edge T+1, the next accepted click can be sampled no earlier than edge T+1+HOLDOFF.
- Mouse passthrough latency: 1 cycle.
- rgb lags `screen` by 1 cycle. Downstream realigns `screen` if needed.
- Simultaneous events:
  - Click coinciding with holdoff_cnt == 1 is ignored (counter still non-zero that cycle).
  - Click and reset together: reset wins.

## Test plan
- Reset with left_button held at 1, then release rst -> screen = 0, no screen_changed pulse, rgb = rgb_screens slice 0 one cycle later.
- N_SCREENS = 4, screen-0 box (452..581, 354..379) with target 2. Rising click at (500, 360) -> screen = 2 one cycle later, single screen_changed pulse, rgb = slice 2 at the following cycle, busy high for 1023 cycles.
- On screen 2, click at (1000, 20) inside EXIT while busy is high -> ignored. Repeat after busy falls -> screen = 0, one pulse.
- Hold left_button for 5000 cycles over the screen-0 nav box -> exactly one transition. A click at (993, 10), the EXIT corner, while on screen 0 -> no change.
- Overlapping nav and EXIT boxes on screen 1, click in the overlap -> screen = 0 (EXIT priority). BTN_TARGET slice = 3'd5 with N_SCREENS = 5 and SCREEN_W = 3 -> click ignored.
- Assert rst low mid-hold-off at count 400 -> immediate return to screen 0 with busy = 0. After release, a fresh click is accepted with no hold-off.

Source files
------------

// File: rtl/screen_nav_control.sv
// Screen-navigation controller: decodes edge-detected, rate-limited mouse clicks
// against per-screen nav buttons and a global EXIT button, and muxes the active screen's colour.
module screen_nav_control #(
    parameter int N_SCREENS = 4,
    parameter int SCREEN_W  = 2,
    parameter int COORD_W   = 12,
    parameter int RGB_W     = 12,
    parameter logic [N_SCREENS*COORD_W-1:0]  BTN_X0     = '0,
    parameter logic [N_SCREENS*COORD_W-1:0]  BTN_X1     = '0,
    parameter logic [N_SCREENS*COORD_W-1:0]  BTN_Y0     = '0,
    parameter logic [N_SCREENS*COORD_W-1:0]  BTN_Y1     = '0,
    parameter logic [N_SCREENS*SCREEN_W-1:0] BTN_TARGET = '0,
    parameter logic [COORD_W-1:0] EXIT_X0 = COORD_W'(993),
    parameter logic [COORD_W-1:0] EXIT_X1 = COORD_W'(1013),
    parameter logic [COORD_W-1:0] EXIT_Y0 = COORD_W'(10),
    parameter logic [COORD_W-1:0] EXIT_Y1 = COORD_W'(30),
    parameter int HOLDOFF = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COORD_W-1:0]         xpos_mouse,
    input  logic [COORD_W-1:0]         ypos_mouse,
    input  logic                       left_button,
    input  logic [N_SCREENS*RGB_W-1:0] rgb_screens,
    output logic [COORD_W-1:0]         xpos_mouse_out,
    output logic [COORD_W-1:0]         ypos_mouse_out,
    output logic [RGB_W-1:0]           rgb,
    output logic [SCREEN_W-1:0]        screen,
    output logic                       screen_changed,
    output logic                       busy
);

    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0]       HOLD_LOAD = HW'(HOLDOFF);
    localparam logic [SCREEN_W:0]   N_LIM     = (SCREEN_W + 1)'(N_SCREENS);

    logic                btn_prev;
    logic [HW-1:0]       holdoff_cnt;
    logic [COORD_W-1:0]  cur_x0, cur_x1, cur_y0, cur_y1;
    logic [SCREEN_W-1:0] cur_tgt;
    logic [RGB_W-1:0]    cur_rgb;
    logic                click, nav_hit, exit_hit, transition;
    logic [SCREEN_W-1:0] next_screen;

    // Per-screen table lookup keyed by the registered screen index
    always_comb begin
        cur_x0  = '0;
        cur_x1  = '0;
        cur_y0  = '0;
        cur_y1  = '0;
        cur_tgt = '0;
        cur_rgb = '0;
        for (int i = 0; i < N_SCREENS; i++) begin
            if (screen == SCREEN_W'(i)) begin
                cur_x0  = BTN_X0[i*COORD_W +: COORD_W];
                cur_x1  = BTN_X1[i*COORD_W +: COORD_W];
                cur_y0  = BTN_Y0[i*COORD_W +: COORD_W];
                cur_y1  = BTN_Y1[i*COORD_W +: COORD_W];
                cur_tgt = BTN_TARGET[i*SCREEN_W +: SCREEN_W];
                cur_rgb = rgb_screens[i*RGB_W +: RGB_W];
            end
        end
    end

    assign click    = left_button & ~btn_prev & (holdoff_cnt == '0);
    assign nav_hit  = (xpos_mouse >= cur_x0) && (xpos_mouse <= cur_x1) &&
                      (ypos_mouse >= cur_y0) && (ypos_mouse <= cur_y1);
    assign exit_hit = (xpos_mouse >= EXIT_X0) && (xpos_mouse <= EXIT_X1) &&
                      (ypos_mouse >= EXIT_Y0) && (ypos_mouse <= EXIT_Y1);

    // EXIT wins over an overlapping nav box; bad or self targets leave the screen alone
    always_comb begin
        next_screen = screen;
        if (click) begin
            if (exit_hit && (screen != '0)) begin
                next_screen = '0;
            end else if (nav_hit && ({1'b0, cur_tgt} < N_LIM) && (cur_tgt != screen)) begin
                next_screen = cur_tgt;
            end
        end
    end

    assign transition = (next_screen != screen);
    assign busy       = (holdoff_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            screen         <= '0;
            screen_changed <= 1'b0;
            btn_prev       <= 1'b1;
            holdoff_cnt    <= '0;
            rgb            <= '0;
            xpos_mouse_out <= '0;
            ypos_mouse_out <= '0;
        end else begin
            screen         <= next_screen;
            screen_changed <= transition;
            btn_prev       <= left_button;
            rgb            <= cur_rgb;
            xpos_mouse_out <= xpos_mouse;
            ypos_mouse_out <= ypos_mouse;
            if (transition) begin
                holdoff_cnt <= HOLD_LOAD;
            end else if (holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_screen_nav_control.sv
// Bench for screen_nav_control: two configurations driven by shared stimulus,
// directed scenarios followed by random traffic, checked against a cycle-level model.
module tb_screen_nav_control;

    localparam logic [47:0] A_X0 = {12'd300, 12'd100, 12'd980,  12'd452};
    localparam logic [47:0] A_X1 = {12'd400, 12'd200, 12'd1020, 12'd581};
    localparam logic [47:0] A_Y0 = {12'd300, 12'd100, 12'd0,    12'd354};
    localparam logic [47:0] A_Y1 = {12'd400, 12'd200, 12'd40,   12'd379};
    localparam logic [7:0]  A_T  = {2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [59:0] B_X0 = {12'd600, A_X0};
    localparam logic [59:0] B_X1 = {12'd700, A_X1};
    localparam logic [59:0] B_Y0 = {12'd600, A_Y0};
    localparam logic [59:0] B_Y1 = {12'd700, A_Y1};
    localparam logic [14:0] B_T  = {3'd3, 3'd1, 3'd5, 3'd2, 3'd4};

    typedef struct {
        int scr;
        bit prev;
        int hold;
        bit chg;
        int rgb;
        int xo;
        int yo;
    } model_t;

    int bx0 [2][5] = '{'{452, 980, 100, 300, 0}, '{452, 980, 100, 300, 600}};
    int bx1 [2][5] = '{'{581, 1020, 200, 400, 0}, '{581, 1020, 200, 400, 700}};
    int by0 [2][5] = '{'{354, 0, 100, 300, 0}, '{354, 0, 100, 300, 600}};
    int by1 [2][5] = '{'{379, 40, 200, 400, 0}, '{379, 40, 200, 400, 700}};
    int tg  [2][5] = '{'{2, 3, 1, 3, 0}, '{4, 2, 5, 1, 3}};
    int nscr[2]    = '{4, 5};
    int hd  [2]    = '{1023, 7};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] xm, ym;
    logic        lb;
    logic [11:0] rgbs [5];
    logic [47:0] rgb_flat_a;
    logic [59:0] rgb_flat_b;
    logic [11:0] xo_a, yo_a, rgb_a, xo_b, yo_b, rgb_b;
    logic [1:0]  screen_a;
    logic [2:0]  screen_b;
    logic        chg_a, busy_a, chg_b, busy_b;

    model_t m [2];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign rgb_flat_a = {rgbs[3], rgbs[2], rgbs[1], rgbs[0]};
    assign rgb_flat_b = {rgbs[4], rgbs[3], rgbs[2], rgbs[1], rgbs[0]};

    screen_nav_control #(
        .N_SCREENS(4), .SCREEN_W(2), .COORD_W(12), .RGB_W(12),
        .BTN_X0(A_X0), .BTN_X1(A_X1), .BTN_Y0(A_Y0), .BTN_Y1(A_Y1),
        .BTN_TARGET(A_T), .HOLDOFF(1023)
    ) dut_a (
        .clk(clk), .rst(rst), .xpos_mouse(xm), .ypos_mouse(ym), .left_button(lb),
        .rgb_screens(rgb_flat_a), .xpos_mouse_out(xo_a), .ypos_mouse_out(yo_a),
        .rgb(rgb_a), .screen(screen_a), .screen_changed(chg_a), .busy(busy_a)
    );

    screen_nav_control #(
        .N_SCREENS(5), .SCREEN_W(3), .COORD_W(12), .RGB_W(12),
        .BTN_X0(B_X0), .BTN_X1(B_X1), .BTN_Y0(B_Y0), .BTN_Y1(B_Y1),
        .BTN_TARGET(B_T), .HOLDOFF(7)
    ) dut_b (
        .clk(clk), .rst(rst), .xpos_mouse(xm), .ypos_mouse(ym), .left_button(lb),
        .rgb_screens(rgb_flat_b), .xpos_mouse_out(xo_b), .ypos_mouse_out(yo_b),
        .rgb(rgb_b), .screen(screen_b), .screen_changed(chg_b), .busy(busy_b)
    );

    function automatic model_t reset_model();
        model_t r;
        r.scr = 0; r.prev = 1'b1; r.hold = 0; r.chg = 1'b0;
        r.rgb = 0; r.xo = 0; r.yo = 0;
        return r;
    endfunction

    // One clock of the behavioural model, from the inputs present at the edge
    function automatic model_t step(model_t cur, int c);
        model_t nx = cur;
        int  x = int'(xm);
        int  y = int'(ym);
        int  t = tg[c][cur.scr];
        int  dest = cur.scr;
        bit  clk_click = lb && !cur.prev && (cur.hold == 0);
        bit  on_exit = (x >= 993) && (x <= 1013) && (y >= 10) && (y <= 30);
        bit  on_nav  = (x >= bx0[c][cur.scr]) && (x <= bx1[c][cur.scr]) &&
                       (y >= by0[c][cur.scr]) && (y <= by1[c][cur.scr]);
        if (clk_click) begin
            if (on_exit && cur.scr != 0) dest = 0;
            else if (on_nav && t < nscr[c] && t != cur.scr) dest = t;
        end
        nx.rgb  = int'(rgbs[cur.scr]);
        nx.xo   = x;
        nx.yo   = y;
        nx.prev = lb;
        nx.chg  = (dest != cur.scr);
        nx.hold = (dest != cur.scr) ? hd[c] : ((cur.hold > 0) ? cur.hold - 1 : 0);
        nx.scr  = dest;
        return nx;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic compare_all();
        check("a_screen", 32'(screen_a), m[0].scr);
        check("a_changed", 32'(chg_a), 32'(m[0].chg));
        check("a_busy", 32'(busy_a), 32'(m[0].hold != 0));
        check("a_rgb", 32'(rgb_a), m[0].rgb);
        check("a_xout", 32'(xo_a), m[0].xo);
        check("a_yout", 32'(yo_a), m[0].yo);
        check("b_screen", 32'(screen_b), m[1].scr);
        check("b_changed", 32'(chg_b), 32'(m[1].chg));
        check("b_busy", 32'(busy_b), 32'(m[1].hold != 0));
        check("b_rgb", 32'(rgb_b), m[1].rgb);
        check("b_xout", 32'(xo_b), m[1].xo);
        check("b_yout", 32'(yo_b), m[1].yo);
    endtask

    // Called just after a falling edge: drive, clock, update model, compare
    task automatic tick(input int x, input int y, input bit b);
        xm = 12'(x);
        ym = 12'(y);
        lb = b;
        for (int i = 0; i < 5; i++) rgbs[i] = 12'($urandom);
        @(posedge clk);
        #1;
        if (rst) begin
            m[0] = step(m[0], 0);
            m[1] = step(m[1], 1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input int x, input int y);
        tick(x, y, 1'b0);
        tick(x, y, 1'b1);
    endtask

    task automatic wait_idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 1'b0);
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #2;
        m[0] = reset_model();
        m[1] = reset_model();
        compare_all();
        tick(0, 0, 1'b1);
        tick(0, 0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        int pulses;
        bit b;
        int x, y;
        xm = '0; ym = '0; lb = 1'b1;
        for (int i = 0; i < 5; i++) rgbs[i] = '0;
        m[0] = reset_model();
        m[1] = reset_model();

        #1 rst = 1'b0;
        #1;
        compare_all();
        check("rst_screen", 32'(screen_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        @(negedge clk);
        tick(500, 360, 1'b1);
        tick(500, 360, 1'b1);
        rst = 1'b1;

        // Button held through reset release must not click
        tick(500, 360, 1'b1);
        check("held_rst_screen", 32'(screen_a), 0);
        check("held_rst_pulse", 32'(chg_a), 0);
        check("rgb_slice0", 32'(rgb_a), 32'(rgbs[0]));

        press(500, 360);
        check("nav_to_2", 32'(screen_a), 2);
        check("nav_pulse", 32'(chg_a), 1);
        check("nav_busy", 32'(busy_a), 1);
        tick(500, 360, 1'b1);
        check("pulse_width", 32'(chg_a), 0);
        check("rgb_slice2", 32'(rgb_a), 32'(rgbs[2]));

        // EXIT during hold-off is ignored; busy lasts exactly HOLDOFF cycles
        for (int k = 2; k <= 1022; k++) tick(1000, 20, k == 3);
        check("exit_ignored", 32'(screen_a), 2);
        check("busy_last", 32'(busy_a), 1);
        tick(1000, 20, 1'b0);
        check("busy_fell", 32'(busy_a), 0);
        tick(1000, 20, 1'b1);
        check("exit_to_0", 32'(screen_a), 0);
        check("exit_pulse", 32'(chg_a), 1);

        wait_idle(1030);
        pulses = 0;
        for (int k = 0; k < 5000; k++) begin
            tick(500, 360, 1'b1);
            if (chg_a) pulses++;
        end
        check("long_hold_one", pulses, 1);
        check("long_hold_scr", 32'(screen_a), 2);
        tick(500, 360, 1'b0);
        press(1000, 20);
        check("exit_again", 32'(screen_a), 0);
        wait_idle(1030);
        press(993, 10);
        check("exit_on_menu", 32'(screen_a), 0);
        check("exit_on_menu_p", 32'(chg_a), 0);

        // Walk the five-screen instance to its out-of-range target
        wait_idle(20);
        press(500, 360);
        wait_idle(10);
        press(650, 650);
        wait_idle(10);
        press(350, 350);
        wait_idle(10);
        press(985, 35);
        check("b_to_2", 32'(screen_b), 2);
        wait_idle(10);
        press(150, 150);
        check("b_target_oob", 32'(screen_b), 2);
        check("b_oob_pulse", 32'(chg_b), 0);

        wait_idle(1030);
        press(150, 150);
        check("a_to_1", 32'(screen_a), 1);
        wait_idle(1030);
        press(1000, 20);
        check("exit_priority", 32'(screen_a), 0);

        // Reset in the middle of hold-off
        wait_idle(1030);
        press(500, 360);
        for (int k = 0; k < 2000 && m[0].hold != 400; k++) tick(0, 0, 1'b0);
        check("mid_hold_busy", 32'(busy_a), 1);
        rst = 1'b0;
        #2;
        m[0] = reset_model();
        m[1] = reset_model();
        check("mid_rst_screen", 32'(screen_a), 0);
        check("mid_rst_busy", 32'(busy_a), 0);
        check("mid_rst_pulse", 32'(chg_a), 0);
        compare_all();
        tick(500, 360, 1'b0);
        tick(500, 360, 1'b0);
        rst = 1'b1;
        press(500, 360);
        check("post_rst_click", 32'(screen_a), 2);

        // Random traffic
        b = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            case ($urandom_range(0, 6))
                0: begin x = $urandom_range(452, 581);  y = $urandom_range(354, 379); end
                1: begin x = $urandom_range(993, 1013); y = $urandom_range(10, 30);   end
                2: begin x = $urandom_range(100, 200);  y = $urandom_range(100, 200); end
                3: begin x = $urandom_range(300, 400);  y = $urandom_range(300, 400); end
                4: begin x = $urandom_range(600, 700);  y = $urandom_range(600, 700); end
                5: begin x = $urandom_range(980, 1020); y = $urandom_range(0, 40);    end
                default: begin x = $urandom_range(0, 4095); y = $urandom_range(0, 4095); end
            endcase
            if ($urandom_range(0, 3) == 0) b = ~b;
            tick(x, y, b);
            if ($urandom_range(0, 4999) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
